irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter N_SRC, default 8, meaning number of external interrupt sources (1..31).
REQ-002 SHALL have port clk_i  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port irq_src_i  input  N_SRC  raw source lines, asynchronous to clk_i.
REQ-005 SHALL have port meip_o  output  1  machine external interrupt request to core.
REQ-006 SHALL have port ack_i  input  1  core acknowledge; one-cycle pulse when core enters the external-interrupt trap.
REQ-007 SHALL have port bus_req_i  input  1  register access request, single-cycle pulse.
REQ-008 SHALL have port bus_we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port bus_addr_i  input  4  byte address; bits [3:2] select the register.
REQ-010 SHALL have port bus_wdata_i  input  32  write data.
REQ-011 SHALL have port bus_rdata_o  output  32  read data, valid while bus_ack_o = 1.
REQ-012 SHALL have port bus_ack_o  output  1  access-complete pulse.

Function
REQ-013 SHALL pass each irq_src_i bit through a 2-flop synchronizer; all logic below uses synchronized values.
REQ-014 SHALL provide registers: 0x0 ENABLE (RW), 0x4 PENDING (RO), 0x8 TRIGGER (RW, 1 = rising-edge, 0 = level), 0xC CLAIM (read: claim_id; write: complete).
REQ-015 Edge source: pending bit set on synchronized 0->1 transition, cleared only when that source is claimed; set wins over clear in the same cycle.
REQ-016 Level source: pending bit equals the synchronized level; never cleared by claim.
REQ-017 Priority SHALL be fixed: lowest source index wins; source i has ID i+1; ID 0 = none.
REQ-018 FSM states: IDLE, ASSERT, IN_SERVICE.
REQ-019 IDLE -> ASSERT when (PENDING & ENABLE) != 0; evaluated every cycle.
REQ-020 ASSERT: meip_o = 1 (registered, first high the cycle after entry); if (PENDING & ENABLE) becomes 0 before ack_i, return to IDLE with meip_o = 0.
REQ-021 ASSERT with ack_i = 1: latch claim_id = ID of highest-priority enabled pending source, clear its pending bit if edge, go to IN_SERVICE, meip_o = 0 next cycle.
REQ-022 ack_i in IDLE or IN_SERVICE SHALL be ignored; ack_i in ASSERT with nothing pending SHALL latch claim_id = 0 and go to IN_SERVICE.
REQ-023 IN_SERVICE: meip_o = 0; new edges still set pending; write to 0xC with bus_wdata_i[4:0] == claim_id returns to IDLE and clears claim_id to 0; mismatched write ignored.
REQ-024 Bus: read or write accepted when bus_req_i = 1; bus_ack_o = 1 exactly one cycle later; bus_rdata_o is registered, 0 when not acking.
REQ-025 Register bits at or above N_SRC SHALL read 0 and ignore writes; CLAIM reads {27'b0, claim_id}.
REQ-026 Writes to PENDING SHALL be ignored; write to TRIGGER does not alter current pending bits.
REQ-027 bus_req_i while bus_ack_o = 1 SHALL be accepted (back-to-back, one access per cycle).

Reset
REQ-028 reset_i low SHALL asynchronously clear synchronizers, ENABLE, PENDING, TRIGGER, claim_id, bus_rdata_o, bus_ack_o, meip_o to 0 and FSM to IDLE.
REQ-029 Reset asserted mid-operation (any state) SHALL abandon any claim; no pending state survives.

Structure
REQ-030 Register offsets, FSM state encodings and ID width SHALL live in a shared package irq_pkg.
REQ-031 Priority selection SHALL be a sub-module irq_prio_enc (N_SRC-bit vector -> 5-bit ID, 0 if none).

Verification
REQ-032 ENABLE=0x01, TRIGGER=0x01, pulse src0 -> meip_o high within 4 cycles; ack_i -> CLAIM reads 0x1, PENDING bit0 = 0, meip_o low.
REQ-033 ENABLE=0x0C, edges on src3 and src2 same cycle, ack -> CLAIM = 3; complete(3) -> meip_o reasserts, next ack -> CLAIM = 4.
REQ-034 Level src5 held high, ENABLE=0x20, ack, complete(6) -> meip_o reasserts; drop src5 while in ASSERT -> FSM IDLE, meip_o = 0.
REQ-035 In IN_SERVICE, write CLAIM with 2 while claim_id = 1 -> state unchanged; write 1 -> IDLE.
REQ-036 Edge on src1 coincident with its claim -> PENDING bit1 remains 1 after claim.
REQ-037 Assert reset_i in IN_SERVICE -> all registers 0, meip_o = 0, bus read of 0xC returns 0 after release.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states, ID width.
package irq_pkg;

    localparam int unsigned ID_W = 5;

    // Register select values taken from bus_addr_i[3:2]
    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_TRIGGER = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ASSERT     = 2'd1,
        ST_IN_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins, source i reports ID i+1, 0 when empty.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC = 8
) (
    input  logic [N_SRC-1:0] req_i,
    output logic [ID_W-1:0]  id_o
);

    // Scan from the top so the lowest index is written last and wins
    always_comb begin
        id_o = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (req_i[N_SRC-1-i]) begin
                id_o = ID_W'(N_SRC - i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Single-target interrupt controller: synchronized sources, edge/level pending,
// fixed priority, claim/complete handshake and a small register bus.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_SRC-1:0] irq_src_i,
    output logic             meip_o,
    input  logic             ack_i,
    input  logic             bus_req_i,
    input  logic             bus_we_i,
    input  logic [3:0]       bus_addr_i,
    input  logic [31:0]      bus_wdata_i,
    output logic [31:0]      bus_rdata_o,
    output logic             bus_ack_o
);

    logic [N_SRC-1:0] sync1_q, sync2_q, sync3_q;
    logic [N_SRC-1:0] enable_q, trigger_q, pending_q;
    logic [N_SRC-1:0] active, rise, claim_clr;
    logic [ID_W-1:0]  top_id, claim_id_q;
    logic [31:0]      rdata_mux;
    logic             reg_wr, complete_wr;
    irq_state_t       state_q;
    logic             unused_ok;

    assign unused_ok   = ^{bus_addr_i[1:0], bus_wdata_i};
    assign reg_wr      = bus_req_i & bus_we_i;
    assign complete_wr = reg_wr && (bus_addr_i[3:2] == REG_CLAIM);
    assign active      = pending_q & enable_q;
    assign rise        = sync2_q & ~sync3_q;

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .req_i (active),
        .id_o  (top_id)
    );

    always_comb begin
        claim_clr = '0;
        if (state_q == ST_ASSERT && ack_i) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (top_id == ID_W'(i + 1)) begin
                    claim_clr[i] = 1'b1;
                end
            end
        end
    end

    // sync3_q only remembers the previous synchronized value for edge detection
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Edge bits: a new rise beats a same-cycle claim. Level bits track the line.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= (trigger_q & (rise | (pending_q & ~claim_clr)))
                       | (~trigger_q & sync2_q);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            enable_q  <= '0;
            trigger_q <= '0;
        end else if (reg_wr) begin
            if (bus_addr_i[3:2] == REG_ENABLE)  enable_q  <= bus_wdata_i[N_SRC-1:0];
            if (bus_addr_i[3:2] == REG_TRIGGER) trigger_q <= bus_wdata_i[N_SRC-1:0];
        end
    end

    always_comb begin
        rdata_mux = '0;
        unique case (bus_addr_i[3:2])
            REG_ENABLE:  rdata_mux = 32'(enable_q);
            REG_PENDING: rdata_mux = 32'(pending_q);
            REG_TRIGGER: rdata_mux = 32'(trigger_q);
            REG_CLAIM:   rdata_mux = 32'(claim_id_q);
            default:     rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            bus_ack_o   <= 1'b0;
            bus_rdata_o <= '0;
        end else begin
            bus_ack_o   <= bus_req_i;
            bus_rdata_o <= (bus_req_i && !bus_we_i) ? rdata_mux : '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            meip_o     <= 1'b0;
            claim_id_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (active != '0) begin
                        state_q <= ST_ASSERT;
                        meip_o  <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (ack_i) begin
                        claim_id_q <= top_id;
                        state_q    <= ST_IN_SERVICE;
                        meip_o     <= 1'b0;
                    end else if (active == '0) begin
                        state_q <= ST_IDLE;
                        meip_o  <= 1'b0;
                    end
                end
                ST_IN_SERVICE: begin
                    meip_o <= 1'b0;
                    if (complete_wr && bus_wdata_i[ID_W-1:0] == claim_id_q) begin
                        state_q    <= ST_IDLE;
                        claim_id_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    meip_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized traffic against a
// cycle-level reference model of the controller's rules.
module tb_irq_controller;

    localparam int unsigned N = 8;
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_SERV = 2;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic [N-1:0]  irq_src_i = '0;
    logic          meip_o;
    logic          ack_i = 1'b0;
    logic          bus_req_i = 1'b0;
    logic          bus_we_i = 1'b0;
    logic [3:0]    bus_addr_i = '0;
    logic [31:0]   bus_wdata_i = '0;
    logic [31:0]   bus_rdata_o;
    logic          bus_ack_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    irq_controller #(.N_SRC(N)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .irq_src_i   (irq_src_i),
        .meip_o      (meip_o),
        .ack_i       (ack_i),
        .bus_req_i   (bus_req_i),
        .bus_we_i    (bus_we_i),
        .bus_addr_i  (bus_addr_i),
        .bus_wdata_i (bus_wdata_i),
        .bus_rdata_o (bus_rdata_o),
        .bus_ack_o   (bus_ack_o)
    );

    // Reference model state
    logic [N-1:0] m_s1, m_s2, m_s3, m_pend, m_en, m_trig;
    int           m_state, m_claim;
    logic         m_meip, m_back;
    logic [31:0]  m_rdata;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_s3 = '0;
        m_pend = '0; m_en = '0; m_trig = '0;
        m_state = M_IDLE; m_claim = 0;
        m_meip = 1'b0; m_back = 1'b0; m_rdata = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] act, np, clr;
        logic [31:0]  rd;
        logic         done;
        int           best;
        if (!reset_i) begin
            model_reset();
            return;
        end
        act = m_pend & m_en;
        best = 0;
        for (int i = N - 1; i >= 0; i--) if (act[i]) best = i + 1;
        rd = '0;
        if (bus_req_i && !bus_we_i) begin
            case (bus_addr_i[3:2])
                2'd0: rd = 32'(m_en);
                2'd1: rd = 32'(m_pend);
                2'd2: rd = 32'(m_trig);
                default: rd = 32'(m_claim);
            endcase
        end
        m_back = bus_req_i;
        m_rdata = rd;
        done = bus_req_i && bus_we_i && bus_addr_i[3:2] == 2'd3
               && bus_wdata_i[4:0] == 5'(m_claim);
        clr = '0;
        case (m_state)
            M_IDLE: if (act != '0) begin m_state = M_WAIT; m_meip = 1'b1; end
            M_WAIT: begin
                if (ack_i) begin
                    m_claim = best;
                    if (best != 0) clr[best-1] = 1'b1;
                    m_state = M_SERV;
                    m_meip = 1'b0;
                end else if (act == '0) begin
                    m_state = M_IDLE;
                    m_meip = 1'b0;
                end
            end
            default: if (done) begin m_state = M_IDLE; m_claim = 0; end
        endcase
        for (int i = 0; i < N; i++) begin
            if (m_trig[i]) np[i] = (m_s2[i] && !m_s3[i]) || (m_pend[i] && !clr[i]);
            else           np[i] = m_s2[i];
        end
        m_pend = np;
        if (bus_req_i && bus_we_i) begin
            if (bus_addr_i[3:2] == 2'd0) m_en = bus_wdata_i[N-1:0];
            if (bus_addr_i[3:2] == 2'd2) m_trig = bus_wdata_i[N-1:0];
        end
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq_src_i;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        irq_src_i = '0; ack_i = 1'b0; bus_req_i = 1'b0; bus_we_i = 1'b0;
        reset_i = 1'b0;
        model_reset();
        tick(); tick();
        reset_i = 1'b1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = a; bus_wdata_i = d;
        tick();
        bus_req_i = 1'b0; bus_we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic ok);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = a;
        tick();
        d = bus_rdata_o; ok = bus_ack_o;
        bus_req_i = 1'b0;
    endtask

    task automatic wait_meip(input int limit);
        int n = 0;
        while (meip_o !== 1'b1 && n < limit) begin tick(); n++; end
    endtask

    task automatic pulse_ack();
        ack_i = 1'b1; tick(); ack_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic ok;
        apply_reset();
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL reset_meip: got %0b expected 0", meip_o); end
        checks++; if (bus_ack_o !== 1'b0 || bus_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_bus: ack %0b rdata %0h expected 0/0", bus_ack_o, bus_rdata_o); end
        for (int r = 0; r < 4; r++) begin
            bus_read(4'(r * 4), d, ok);
            checks++; if (d !== 32'h0 || ok !== 1'b1) begin errors++; $display("FAIL reset_reg%0d: got %0h ack %0b expected 0 ack 1", r, d, ok); end
        end
        tick();
        checks++; if (bus_ack_o !== 1'b0 || bus_rdata_o !== 32'h0) begin errors++; $display("FAIL idle_bus: ack %0b rdata %0h expected 0/0", bus_ack_o, bus_rdata_o); end
    endtask

    task automatic test_edge_basic();
        logic [31:0] d; logic ok;
        apply_reset();
        bus_write(4'h0, 32'h1); bus_write(4'h8, 32'h1);
        irq_src_i[0] = 1'b1;
        wait_meip(4);
        checks++; if (meip_o !== 1'b1) begin errors++; $display("FAIL edge_meip_latency: got %0b expected 1 within 4 cycles", meip_o); end
        irq_src_i[0] = 1'b0;
        pulse_ack();
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL edge_meip_after_ack: got %0b expected 0", meip_o); end
        bus_read(4'hC, d, ok);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL edge_claim: got %0h expected 1", d); end
        bus_read(4'h4, d, ok);
        checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL edge_pending0: got %0b expected 0", d[0]); end
        bus_write(4'hC, 32'h1);
        bus_read(4'hC, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_claim_cleared: got %0h expected 0", d); end
    endtask

    task automatic test_two_edges();
        logic [31:0] d; logic ok;
        apply_reset();
        bus_write(4'h0, 32'h0C); bus_write(4'h8, 32'h0C);
        irq_src_i = 8'h0C;
        wait_meip(4);
        pulse_ack();
        bus_read(4'hC, d, ok);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL prio_first_claim: got %0h expected 3", d); end
        bus_write(4'hC, 32'h3);
        wait_meip(4);
        checks++; if (meip_o !== 1'b1) begin errors++; $display("FAIL prio_reassert: got %0b expected 1", meip_o); end
        pulse_ack();
        bus_read(4'hC, d, ok);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL prio_second_claim: got %0h expected 4", d); end
        bus_write(4'hC, 32'h4);
        irq_src_i = '0;
    endtask

    task automatic test_level();
        logic [31:0] d; logic ok;
        apply_reset();
        bus_write(4'h0, 32'h20);
        irq_src_i[5] = 1'b1;
        wait_meip(4);
        pulse_ack();
        bus_read(4'hC, d, ok);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL level_claim: got %0h expected 6", d); end
        bus_write(4'hC, 32'h6);
        wait_meip(4);
        checks++; if (meip_o !== 1'b1) begin errors++; $display("FAIL level_reassert: got %0b expected 1", meip_o); end
        irq_src_i[5] = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL level_drop_meip: got %0b expected 0", meip_o); end
        bus_read(4'h4, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL level_drop_pending: got %0h expected 0", d); end
    endtask

    task automatic test_mismatch();
        logic [31:0] d; logic ok;
        apply_reset();
        bus_write(4'h0, 32'h1); bus_write(4'h8, 32'h1);
        irq_src_i[0] = 1'b1;
        wait_meip(4);
        irq_src_i[0] = 1'b0;
        pulse_ack();
        bus_write(4'hC, 32'h2);
        bus_read(4'hC, d, ok);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL mismatch_claim_kept: got %0h expected 1", d); end
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL mismatch_meip: got %0b expected 0", meip_o); end
        bus_write(4'hC, 32'h1);
        bus_read(4'hC, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL match_complete: got %0h expected 0", d); end
    endtask

    task automatic test_coincident();
        logic [31:0] d; logic ok;
        apply_reset();
        bus_write(4'h0, 32'h2); bus_write(4'h8, 32'h2);
        irq_src_i[1] = 1'b1;
        wait_meip(4);
        irq_src_i[1] = 1'b0;
        tick(); tick(); tick();
        irq_src_i[1] = 1'b1;
        tick(); tick();
        pulse_ack();
        irq_src_i[1] = 1'b0;
        bus_read(4'h4, d, ok);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL coincident_pending: got %0h expected 2", d); end
        bus_read(4'hC, d, ok);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL coincident_claim: got %0h expected 2", d); end
        bus_write(4'hC, 32'h2);
        wait_meip(4);
        checks++; if (meip_o !== 1'b1) begin errors++; $display("FAIL coincident_reassert: got %0b expected 1", meip_o); end
    endtask

    task automatic test_reset_in_service();
        logic [31:0] d; logic ok;
        apply_reset();
        bus_write(4'h0, 32'hFF); bus_write(4'h8, 32'h0F);
        irq_src_i = 8'h31;
        wait_meip(4);
        pulse_ack();
        #2 reset_i = 1'b0;
        model_reset();
        #1;
        checks++; if (meip_o !== 1'b0 || bus_ack_o !== 1'b0 || bus_rdata_o !== 32'h0) begin errors++; $display("FAIL async_reset_outputs: meip %0b ack %0b rdata %0h expected 0", meip_o, bus_ack_o, bus_rdata_o); end
        irq_src_i = '0;
        @(negedge clk_i);
        tick();
        reset_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bus_read(4'(12 - r * 4), d, ok);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_reg%0d: got %0h expected 0", 3 - r, d); end
        end
        checks++; if (meip_o !== 1'b0) begin errors++; $display("FAIL post_reset_meip: got %0b expected 0", meip_o); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus_write(4'h0, 32'hFFFF_FF5A);
        bus_write(4'h8, 32'h33);
        bus_req_i = 1'b1; bus_we_i = 1'b0;
        bus_addr_i = 4'h0; tick();
        checks++; if (bus_ack_o !== 1'b1 || bus_rdata_o !== 32'h5A) begin errors++; $display("FAIL b2b_enable: ack %0b rdata %0h expected 1/5a", bus_ack_o, bus_rdata_o); end
        bus_addr_i = 4'h8; tick();
        checks++; if (bus_ack_o !== 1'b1 || bus_rdata_o !== 32'h33) begin errors++; $display("FAIL b2b_trigger: ack %0b rdata %0h expected 1/33", bus_ack_o, bus_rdata_o); end
        bus_we_i = 1'b1; bus_addr_i = 4'h4; bus_wdata_i = 32'hFF; tick();
        checks++; if (bus_ack_o !== 1'b1 || bus_rdata_o !== 32'h0) begin errors++; $display("FAIL b2b_write_ack: ack %0b rdata %0h expected 1/0", bus_ack_o, bus_rdata_o); end
        bus_we_i = 1'b0; tick();
        checks++; if (bus_rdata_o !== 32'h0) begin errors++; $display("FAIL pending_write_ignored: got %0h expected 0", bus_rdata_o); end
        bus_req_i = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) irq_src_i = irq_src_i ^ N'(1 << $urandom_range(0, N - 1));
            ack_i = ($urandom_range(0, 5) == 0);
            bus_req_i = ($urandom_range(0, 2) != 0);
            bus_we_i = $urandom_range(0, 1) == 1;
            bus_addr_i = 4'($urandom_range(0, 3) << 2) | 4'($urandom_range(0, 3));
            if (bus_addr_i[3:2] == 2'd3 && $urandom_range(0, 1) == 1) bus_wdata_i = 32'(m_claim);
            else bus_wdata_i = $urandom;
            tick();
            checks++; if (meip_o !== m_meip) begin errors++; $display("FAIL rand_meip c%0d: got %0b expected %0b", c, meip_o, m_meip); end
            checks++; if (bus_ack_o !== m_back) begin errors++; $display("FAIL rand_bus_ack c%0d: got %0b expected %0b", c, bus_ack_o, m_back); end
            checks++; if (bus_rdata_o !== m_rdata) begin errors++; $display("FAIL rand_rdata c%0d: got %0h expected %0h", c, bus_rdata_o, m_rdata); end
        end
        ack_i = 1'b0; bus_req_i = 1'b0; bus_we_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_two_edges();
        test_level();
        test_mismatch();
        test_coincident();
        test_reset_in_service();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
